// File: rtl/audio_pkg.sv
// Shared audio-path definitions: default sample word geometry and the sample type.
package audio_pkg;

    // Default sample word width in bits.
    localparam int SAMPLE_WIDTH = 24;

    // Default sample FIFO entry count (power of two, 2..64).
    localparam int FIFO_DEPTH = 8;

    // One audio sample word at the default width.
    typedef logic [SAMPLE_WIDTH-1:0] sample_t;

endpackage : audio_pkg

// File: rtl/sample_fifo_mem.sv
// Sample storage: one synchronous write port and one asynchronous read port.
// Contents are never reset; stale entries are hidden by the controller's valid flag.
module sample_fifo_mem
    import audio_pkg::*;
#(
    parameter int WIDTH = SAMPLE_WIDTH,
    parameter int DEPTH = FIFO_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write the incoming sample into the addressed entry.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Head entry is read combinationally so the FIFO can fall through.
    assign rdata = mem[raddr];

endmodule : sample_fifo_mem

// File: rtl/sample_fifo.sv
// First-word-fall-through sample FIFO with a sticky overflow flag.
// Writes arriving while full with no concurrent read are dropped and flagged.
module sample_fifo
    import audio_pkg::*;
#(
    parameter int WIDTH = SAMPLE_WIDTH,
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_data,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow,
    input  logic                     clr_overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);

    logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [CW-1:0] count_reg, count_next;
    logic          overflow_reg, overflow_next;

    logic push;
    logic pop;
    logic drop;
    logic full_int;
    logic empty_int;

    // Status flags come only from the registered occupancy.
    assign full_int  = (count_reg == COUNT_FULL);
    assign empty_int = (count_reg == '0);

    // Handshake decode: a full FIFO still accepts a write when the head leaves this cycle.
    always_comb begin
        pop  = ~empty_int & out_ready;
        push = wr_en & (~full_int | pop);
        drop = wr_en & full_int & ~pop;
    end

    // Next-state for pointers, occupancy and the sticky overflow flag.
    always_comb begin
        rd_ptr_next   = rd_ptr_reg;
        wr_ptr_next   = wr_ptr_reg;
        count_next    = count_reg;
        overflow_next = overflow_reg;

        // Pointers are exactly AW bits wide, so DEPTH-1 wraps to 0 with no gap.
        if (push) begin
            wr_ptr_next = wr_ptr_reg + AW'(1);
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + AW'(1);
        end

        if (push && !pop) begin
            count_next = count_reg + CW'(1);
        end else if (pop && !push) begin
            count_next = count_reg - CW'(1);
        end

        // A drop in the same cycle as a clear keeps the flag set.
        if (drop) begin
            overflow_next = 1'b1;
        end else if (clr_overflow) begin
            overflow_next = 1'b0;
        end
    end

    // Control state register; reset discards every stored sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            rd_ptr_reg   <= rd_ptr_next;
            wr_ptr_reg   <= wr_ptr_next;
            count_reg    <= count_next;
            overflow_reg <= overflow_next;
        end
    end

    sample_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_reg),
        .wdata (wr_data),
        .raddr (rd_ptr_reg),
        .rdata (out_data)
    );

    assign out_valid = ~empty_int;
    assign count     = count_reg;
    assign full      = full_int;
    assign empty     = empty_int;
    assign overflow  = overflow_reg;

endmodule : sample_fifo

// File: tb/tb_sample_fifo.sv
// Directed bench for sample_fifo at the default 24-bit x 8 geometry.
module tb_sample_fifo;

    logic        clk;
    logic        reset;
    logic        wr_en;
    logic [23:0] wr_data;
    logic        out_valid;
    logic [23:0] out_data;
    logic        out_ready;
    logic [3:0]  count;
    logic        full;
    logic        empty;
    logic        overflow;
    logic        clr_overflow;

    int total = 0;
    int bad   = 0;

    sample_fifo #(
        .WIDTH (24),
        .DEPTH (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_ready    (out_ready),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        wr_en = 1'b0;
        out_ready = 1'b0;
        clr_overflow = 1'b0;
        step();
        reset = 1'b0;
    endtask

    task automatic push_one(input logic [23:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        wr_en = 1'b0;
        wr_data = '0;
        out_ready = 1'b0;
        clr_overflow = 1'b0;
        step();
        step();
        reset = 1'b0;
        total++; if (count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b want=1", empty); end
        total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b want=0", full); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b want=0", overflow); end
        $display("reset: count=%0d empty=%b full=%b", count, empty, full);
    endtask

    task automatic test_three_pushes();
        logic [23:0] exp_vals [3];
        exp_vals[0] = 24'h000011;
        exp_vals[1] = 24'h000022;
        exp_vals[2] = 24'h000033;
        do_reset();
        push_one(24'h000011);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL latency_valid got=%b want=1", out_valid); end
        total++; if (out_data !== 24'h000011) begin bad++; $display("FAIL latency_data got=%h want=000011", out_data); end
        push_one(24'h000022);
        push_one(24'h000033);
        total++; if (count !== 4'd3) begin bad++; $display("FAIL three_count got=%0d want=3", count); end
        total++; if (out_data !== 24'h000011) begin bad++; $display("FAIL three_head got=%h want=000011", out_data); end
        // Head must hold while the consumer stalls.
        step();
        total++; if (out_data !== 24'h000011) begin bad++; $display("FAIL stall_head got=%h want=000011", out_data); end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            total++; if (out_data !== exp_vals[i]) begin bad++; $display("FAIL three_drain[%0d] got=%h want=%h", i, out_data, exp_vals[i]); end
            step();
        end
        out_ready = 1'b0;
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL three_empty got=%b want=1", empty); end
        $display("three_pushes: drained, empty=%b", empty);
    endtask

    task automatic test_overflow();
        do_reset();
        for (int v = 1; v <= 8; v++) push_one(24'(v));
        total++; if (full !== 1'b1) begin bad++; $display("FAIL fill_full got=%b want=1", full); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL fill_overflow got=%b want=0", overflow); end
        push_one(24'd9);
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL drop_overflow got=%b want=1", overflow); end
        total++; if (count !== 4'd8) begin bad++; $display("FAIL drop_count got=%0d want=8", count); end
        out_ready = 1'b1;
        for (int v = 1; v <= 8; v++) begin
            total++; if (out_data !== 24'(v)) begin bad++; $display("FAIL drop_drain got=%h want=%h", out_data, 24'(v)); end
            step();
        end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL drop_empty got=%b want=1", empty); end
        // Reading an empty FIFO must not underflow the count.
        step();
        total++; if (count !== 4'd0) begin bad++; $display("FAIL empty_pop_count got=%0d want=0", count); end
        out_ready = 1'b0;
        $display("overflow: overflow=%b count=%0d", overflow, count);
    endtask

    task automatic test_full_push_pop();
        do_reset();
        for (int v = 1; v <= 8; v++) push_one(24'(v));
        wr_en = 1'b1;
        wr_data = 24'h0000AA;
        out_ready = 1'b1;
        step();
        wr_en = 1'b0;
        out_ready = 1'b0;
        total++; if (count !== 4'd8) begin bad++; $display("FAIL fpp_count got=%0d want=8", count); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL fpp_overflow got=%b want=0", overflow); end
        total++; if (out_data !== 24'd2) begin bad++; $display("FAIL fpp_head got=%h want=000002", out_data); end
        out_ready = 1'b1;
        for (int v = 2; v <= 8; v++) begin
            total++; if (out_data !== 24'(v)) begin bad++; $display("FAIL fpp_drain got=%h want=%h", out_data, 24'(v)); end
            step();
        end
        total++; if (out_data !== 24'h0000AA) begin bad++; $display("FAIL fpp_last got=%h want=0000aa", out_data); end
        step();
        out_ready = 1'b0;
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL fpp_empty got=%b want=1", empty); end
        $display("full_push_pop: count=%0d", count);
    endtask

    task automatic test_back_to_back();
        do_reset();
        // Write with out_ready while empty: push only.
        wr_en = 1'b1;
        wr_data = 24'd100;
        out_ready = 1'b1;
        step();
        total++; if (count !== 4'd1) begin bad++; $display("FAIL empty_rw_count got=%0d want=1", count); end
        for (int i = 0; i < 20; i++) begin
            wr_data = 24'(101 + i);
            total++; if (out_data !== 24'(100 + i)) begin bad++; $display("FAIL b2b_data[%0d] got=%h want=%h", i, out_data, 24'(100 + i)); end
            step();
            total++; if (count !== 4'd1) begin bad++; $display("FAIL b2b_count[%0d] got=%0d want=1", i, count); end
        end
        wr_en = 1'b0;
        total++; if (out_data !== 24'd120) begin bad++; $display("FAIL b2b_tail got=%h want=%h", out_data, 24'd120); end
        step();
        out_ready = 1'b0;
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL b2b_empty got=%b want=1", empty); end
        $display("back_to_back: 21 samples streamed, count=%0d", count);
    endtask

    task automatic test_overflow_clear();
        do_reset();
        for (int v = 1; v <= 8; v++) push_one(24'(v));
        push_one(24'd9);
        wr_en = 1'b1;
        wr_data = 24'h000077;
        clr_overflow = 1'b1;
        step();
        wr_en = 1'b0;
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL clr_vs_drop got=%b want=1", overflow); end
        step();
        clr_overflow = 1'b0;
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL clr_alone got=%b want=0", overflow); end
        total++; if (count !== 4'd8) begin bad++; $display("FAIL clr_count got=%0d want=8", count); end
        total++; if (out_data !== 24'd1) begin bad++; $display("FAIL clr_head got=%h want=000001", out_data); end
        $display("overflow_clear: overflow=%b", overflow);
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int v = 0; v < 5; v++) push_one(24'(16 + v));
        total++; if (count !== 4'd5) begin bad++; $display("FAIL mid_pre_count got=%0d want=5", count); end
        reset = 1'b1;
        wr_en = 1'b1;
        wr_data = 24'h000099;
        out_ready = 1'b1;
        step();
        reset = 1'b0;
        wr_en = 1'b0;
        out_ready = 1'b0;
        total++; if (count !== 4'd0) begin bad++; $display("FAIL mid_count got=%0d want=0", count); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_valid got=%b want=0", out_valid); end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL mid_empty got=%b want=1", empty); end
        push_one(24'h000055);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL post_valid got=%b want=1", out_valid); end
        total++; if (out_data !== 24'h000055) begin bad++; $display("FAIL post_data got=%h want=000055", out_data); end
        total++; if (count !== 4'd1) begin bad++; $display("FAIL post_count got=%0d want=1", count); end
        $display("reset_mid: count=%0d head=%h", count, out_data);
    endtask

    initial begin
        test_reset();
        test_three_pushes();
        test_overflow();
        test_full_push_pop();
        test_back_to_back();
        test_overflow_clear();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_sample_fifo
